// File: rtl/task4_top.sv
// ARC4 brute-force key cracker (DE1-SoC top, lab task 4).
//
// Tries 24-bit keys 0x000000..0xFFFFFF in ascending order. For each key it
// rebuilds the S-box (INIT + KSA), then runs the PRGA over the stored
// ciphertext. Each plaintext byte is written to "pt" and checked on the fly.
// The first key whose plaintext is entirely printable (0x20..0x7E) is shown
// on the 7-segment displays. If no key works, dashes are shown instead.
//
// Ports:
//   CLOCK_50    in   sole clock, rising edge
//   KEY[3:0]    in   KEY[3] = synchronous active-low reset, KEY[2:0] unused
//   SW[9:0]     in   unused
//   HEX0..HEX5  out  active-low segments (bit 0 = a); HEX5 = key[23:20]
//   LEDR[9:0]   out  LEDR[0] = done, LEDR[1] = key found, others 0
//
// Memories:
//   ct  - ciphertext ROM; byte 0 = length L, bytes 1..L = ciphertext.
//         Contents live in ct.altsyncram_component.m_default.altsyncram_inst.mem_data
//   s   - S-box RAM, 256x8
//   pt  - plaintext RAM, 256x8; pt[0] = L, pt[1..L] = plaintext
// All three read synchronously with one cycle of latency.
//
// Handshake note: there are no valid/ready interfaces here. The only
// "transaction" is the search itself: it starts when KEY[3] is released and
// completes when LEDR[0] rises, which then holds until the next reset.

// 256x8 single-port synchronous RAM; read returns the old data on a write.
module ram256 (
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] d,
  input  logic       wren,
  output logic [7:0] q
);
  logic [7:0] mem_data [0:255];

  always_ff @(posedge clk) begin
    if (wren) mem_data[addr] <= d;
    q <= mem_data[addr];
  end
endmodule

// Mirrors the hierarchy of the vendor ROM wrapper so the contents can be
// preloaded at ...altsyncram_component.m_default.altsyncram_inst.mem_data.
module ct_altsyncram (
  input  logic       clk,
  input  logic [7:0] address,
  output logic [7:0] q
);
  if (1) begin : m_default
    ram256 altsyncram_inst (
      .clk  (clk),
      .addr (address),
      .d    (8'h00),
      .wren (1'b0),
      .q    (q)
    );
  end
endmodule

// Ciphertext ROM.
module ct_rom (
  input  logic       clock,
  input  logic [7:0] address,
  output logic [7:0] q
);
  ct_altsyncram altsyncram_component (
    .clk     (clock),
    .address (address),
    .q       (q)
  );
endmodule

module task4_top (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  typedef enum logic [3:0] {
    INIT_S,
    KSA_READ_I,
    KSA_CALC_J,
    KSA_READ_J,
    KSA_WRITE_J,
    KSA_WRITE_I,
    PRGA_START,
    PRGA_READ_I,
    PRGA_CALC_J,
    PRGA_READ_J,
    PRGA_WRITE_J,
    PRGA_WRITE_I,
    PRGA_READ_PAD,
    CHECK,
    NEXT_KEY,
    FINISH
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic        rst_n;
  state_t      state;
  logic [23:0] key;
  logic [7:0]  i, j, si, sj, n, len;
  logic [1:0]  km;       // i mod 3 during the KSA
  logic        key_hit;  // search ended on a working key
  logic        done, found;

  logic [7:0]  key_byte;
  logic [7:0]  s_addr, s_d, s_q;
  logic        s_wren;
  logic [7:0]  pt_addr, pt_d, pt_q;
  logic        pt_wren;
  logic [7:0]  ct_q;
  logic [7:0]  plain;
  logic        printable;
  logic        unused_inputs;

  assign rst_n         = KEY[3];
  assign unused_inputs = ^{SW, KEY[2:0], pt_q};
  assign LEDR          = {8'h00, found, done};

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  ct_rom ct (
    .clock   (CLOCK_50),
    .address (n),
    .q       (ct_q)
  );

  ram256 s (
    .clk  (CLOCK_50),
    .addr (s_addr),
    .d    (s_d),
    .wren (s_wren),
    .q    (s_q)
  );

  ram256 pt (
    .clk  (CLOCK_50),
    .addr (pt_addr),
    .d    (pt_d),
    .wren (pt_wren),
    .q    (pt_q)
  );

  always_comb begin
    key_byte = key[7:0];
    case (km)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  end

  // In CHECK, s_q holds the pad byte and ct_q holds ct[n].
  assign plain     = s_q ^ ct_q;
  assign printable = (plain >= 8'h20) && (plain <= 8'h7E);

  // Memory controls decode from registered state only. A swap is split
  // across WRITE_J and WRITE_I so the single S port never sees two writes.
  always_comb begin
    s_addr  = i;
    s_d     = 8'h00;
    s_wren  = 1'b0;
    pt_addr = n;
    pt_d    = 8'h00;
    pt_wren = 1'b0;
    case (state)
      INIT_S:        begin s_d = i; s_wren = 1'b1; end
      KSA_READ_I:    s_addr = i;
      KSA_READ_J:    s_addr = j;
      KSA_WRITE_J:   begin s_addr = j; s_d = si; s_wren = 1'b1; end
      KSA_WRITE_I:   begin s_addr = i; s_d = sj; s_wren = 1'b1; end
      PRGA_START:    begin pt_addr = 8'h00; pt_d = len; pt_wren = 1'b1; end
      PRGA_READ_I:   s_addr = i + 8'd1;
      PRGA_READ_J:   s_addr = j;
      PRGA_WRITE_J:  begin s_addr = j; s_d = si; s_wren = 1'b1; end
      PRGA_WRITE_I:  begin s_addr = i; s_d = sj; s_wren = 1'b1; end
      PRGA_READ_PAD: s_addr = si + sj;  // S[i]+S[j] after the swap
      CHECK:         begin pt_d = plain; pt_wren = 1'b1; end
      default:       ;
    endcase
    if (!rst_n) begin
      s_wren  = 1'b0;
      pt_wren = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state   <= INIT_S;
      key     <= 24'h000000;
      i       <= 8'h00;
      j       <= 8'h00;
      si      <= 8'h00;
      sj      <= 8'h00;
      n       <= 8'h00;
      len     <= 8'h00;
      km      <= 2'd0;
      key_hit <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      HEX0    <= SEG_BLANK;
      HEX1    <= SEG_BLANK;
      HEX2    <= SEG_BLANK;
      HEX3    <= SEG_BLANK;
      HEX4    <= SEG_BLANK;
      HEX5    <= SEG_BLANK;
    end else begin
      case (state)
        INIT_S: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            // n has been 0 for the whole fill, so ct_q is ct[0] = L.
            len   <= ct_q;
            j     <= 8'h00;
            km    <= 2'd0;
            state <= KSA_READ_I;
          end
        end
        KSA_READ_I:  state <= KSA_CALC_J;
        KSA_CALC_J: begin
          si    <= s_q;
          j     <= j + s_q + key_byte;
          state <= KSA_READ_J;
        end
        KSA_READ_J:  state <= KSA_WRITE_J;
        KSA_WRITE_J: begin
          sj    <= s_q;
          state <= KSA_WRITE_I;
        end
        KSA_WRITE_I: begin
          i  <= i + 8'd1;
          km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
          state <= (i == 8'hFF) ? PRGA_START : KSA_READ_I;
        end
        PRGA_START: begin
          i <= 8'h00;
          j <= 8'h00;
          n <= 8'h01;
          if (len == 8'h00) begin
            key_hit <= 1'b1;
            state   <= FINISH;
          end else begin
            state <= PRGA_READ_I;
          end
        end
        PRGA_READ_I: begin
          i     <= i + 8'd1;
          state <= PRGA_CALC_J;
        end
        PRGA_CALC_J: begin
          si    <= s_q;
          j     <= j + s_q;
          state <= PRGA_READ_J;
        end
        PRGA_READ_J:   state <= PRGA_WRITE_J;
        PRGA_WRITE_J: begin
          sj    <= s_q;
          state <= PRGA_WRITE_I;
        end
        PRGA_WRITE_I:  state <= PRGA_READ_PAD;
        PRGA_READ_PAD: state <= CHECK;
        CHECK: begin
          if (!printable) begin
            state <= NEXT_KEY;
          end else if (n == len) begin
            key_hit <= 1'b1;
            state   <= FINISH;
          end else begin
            n     <= n + 8'd1;
            state <= PRGA_READ_I;
          end
        end
        NEXT_KEY: begin
          n <= 8'h00;
          i <= 8'h00;
          if (key == 24'hFFFFFF) begin
            state <= FINISH;
          end else begin
            key   <= key + 24'd1;
            state <= INIT_S;
          end
        end
        FINISH: begin
          // Absorbing; outputs settle one cycle after entry.
          done  <= 1'b1;
          found <= key_hit;
          HEX0  <= key_hit ? seg7(key[3:0])   : SEG_DASH;
          HEX1  <= key_hit ? seg7(key[7:4])   : SEG_DASH;
          HEX2  <= key_hit ? seg7(key[11:8])  : SEG_DASH;
          HEX3  <= key_hit ? seg7(key[15:12]) : SEG_DASH;
          HEX4  <= key_hit ? seg7(key[19:16]) : SEG_DASH;
          HEX5  <= key_hit ? seg7(key[23:20]) : SEG_DASH;
        end
        default: state <= INIT_S;
      endcase
    end
  end

endmodule

// File: tb/tb_task4_top.sv
module tb_task4_top;

  // ---------------- clock / reset ----------------
  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'b0111;
  logic [9:0] SW = 10'h000;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;
  logic [41:0] hex_bus;

  always #10 CLOCK_50 = ~CLOCK_50;

  assign hex_bus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  task4_top dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [6:0] glyph_tbl [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ct_m  [256];
  logic [7:0] ks_m  [256];
  logic [7:0] msg_m [256];

  // ARC4 keystream bytes 1..len for a 24-bit key, straight from the algorithm.
  function automatic void gen_ks(input logic [23:0] k, input int len);
    logic [7:0] sb [256];
    logic [7:0] kb [3];
    logic [7:0] tmp;
    int a, b;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) sb[x] = 8'(x);
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = (b + int'(sb[x]) + int'(kb[x % 3])) % 256;
      tmp = sb[x]; sb[x] = sb[b]; sb[b] = tmp;
    end
    a = 0; b = 0;
    for (int m = 1; m <= len; m++) begin
      a = (a + 1) % 256;
      b = (b + int'(sb[a])) % 256;
      tmp = sb[a]; sb[a] = sb[b]; sb[b] = tmp;
      ks_m[m] = sb[(int'(sb[a]) + int'(sb[b])) % 256];
    end
  endfunction

  function automatic bit key_ok(input logic [23:0] k, input int len);
    logic [7:0] p;
    gen_ks(k, len);
    for (int m = 1; m <= len; m++) begin
      p = ks_m[m] ^ ct_m[m];
      if (p < 8'h20 || p > 8'h7E) return 1'b0;
    end
    return 1'b1;
  endfunction

  // First working key at or above start, or -1 if the key space runs out.
  function automatic int model_search(input int start, input int len);
    for (int k = start; k <= 24'hFFFFFF; k++)
      if (key_ok(24'(k), len)) return k;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic encrypt(input logic [23:0] k, input int len);
    gen_ks(k, len);
    for (int m = 0; m < 256; m++) ct_m[m] = 8'($urandom_range(0, 255));
    ct_m[0] = 8'(len);
    for (int m = 1; m <= len; m++) ct_m[m] = msg_m[m] ^ ks_m[m];
  endtask

  task automatic load_ct();
    for (int m = 0; m < 256; m++)
      dut.ct.altsyncram_component.m_default.altsyncram_inst.mem_data[m] = ct_m[m];
  endtask

  task automatic pulse_reset(input int cyc);
    @(negedge CLOCK_50);
    KEY = 4'b0111;
    repeat (cyc) @(negedge CLOCK_50);
    KEY = 4'b1111;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int cyc = 0;
    while (LEDR[0] !== 1'b1 && cyc < budget) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check({tag, "_done"}, {63'd0, LEDR[0]}, 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hex"}, {22'd0, hex_bus}, {22'd0, {6{7'h7F}}});
    check({tag, "_ledr"}, {54'd0, LEDR}, 64'd0);
  endtask

  task automatic check_result(input string tag, input int exp_key, input int len);
    logic [23:0] k;
    logic [7:0]  e;
    @(negedge CLOCK_50);
    if (exp_key >= 0) begin
      k = 24'(exp_key);
      check({tag, "_ledr"}, {54'd0, LEDR}, 64'h3);
      for (int d = 0; d < 6; d++)
        check($sformatf("%s_hex%0d", tag, d), {57'd0, hex_bus[7*d +: 7]},
              {57'd0, glyph_tbl[k[4*d +: 4]]});
      check({tag, "_pt0"}, {56'd0, dut.pt.mem_data[0]}, 64'(len));
      gen_ks(k, len);
      for (int m = 1; m <= len; m++) exp_q.push_back(ks_m[m] ^ ct_m[m]);
      for (int m = 1; m <= len; m++) begin
        e = exp_q.pop_front();
        check($sformatf("%s_pt%0d", tag, m), {56'd0, dut.pt.mem_data[m]}, {56'd0, e});
      end
    end else begin
      check({tag, "_ledr"}, {54'd0, LEDR}, 64'h1);
      check({tag, "_hex"}, {22'd0, hex_bus}, {22'd0, {6{7'h3F}}});
    end
  endtask

  task automatic run_random(input string tag, input int max_key, input bit do_abort);
    int r, len, exp_key, abort_at;
    r   = $urandom_range(0, max_key);
    len = $urandom_range(1, 6);
    for (int m = 1; m <= len; m++) msg_m[m] = 8'($urandom_range(32, 126));
    encrypt(24'(r), len);
    load_ct();
    exp_key = model_search(0, len);
    pulse_reset(1);
    if (do_abort) begin
      abort_at = (exp_key >= 2) ? 3200 + $urandom_range(0, 200) : $urandom_range(300, 1200);
      repeat (abort_at) @(negedge CLOCK_50);
      KEY = 4'b0111;
      repeat (3) @(negedge CLOCK_50);
      check_idle({tag, "_abort"});
      KEY = 4'b1111;
      repeat (5) @(negedge CLOCK_50);
      check({tag, "_restart_key"}, {40'd0, dut.key}, 64'd0);
    end
    wait_done(tag, 20000);
    check_result(tag, exp_key, len);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string hello;
    int exp_key, c;
    logic [7:0] p1, p2;
    glyph_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    SW = 10'($urandom_range(0, 1023));

    // "hello" under key 0x000018, one-cycle reset pulse.
    hello = "hello";
    for (int m = 1; m <= 5; m++) msg_m[m] = hello[m-1];
    encrypt(24'h000018, 5);
    load_ct();
    exp_key = model_search(0, 5);
    repeat (3) @(negedge CLOCK_50);
    check_idle("por");
    pulse_reset(1);
    wait_done("hello", 60000);
    check_result("hello", exp_key, 5);

    // L=0 with a held reset: displays blank throughout the hold and early search.
    encrypt(24'h000000, 0);
    load_ct();
    @(negedge CLOCK_50);
    KEY = 4'b0111;
    repeat (3) @(negedge CLOCK_50);
    check_idle("hold_a");
    repeat (3) @(negedge CLOCK_50);
    check_idle("hold_b");
    check("hold_key", {40'd0, dut.key}, 64'd0);
    KEY = 4'b1111;
    repeat (50) @(negedge CLOCK_50);
    check_idle("search");
    wait_done("len0", 3000);
    check_result("len0", 0, 0);

    // Single byte "A" under key 0: must stop on the very first key.
    msg_m[1] = 8'h41;
    encrypt(24'h000000, 1);
    load_ct();
    pulse_reset(1);
    wait_done("key0", 3000);
    check_result("key0", model_search(0, 1), 1);
    check("key0_nokeyinc", {40'd0, dut.key}, 64'd0);

    // Random messages, one with a reset in the middle of the search.
    run_random("rnd_abort", 6, 1'b1);
    run_random("rnd_a", 3, 1'b0);
    run_random("rnd_b", 3, 1'b0);

    // Exhaustion: jump the search to 0xFFFFFE with a byte that neither of the
    // last two keys can decrypt to printable text.
    gen_ks(24'hFFFFFE, 1);
    p1 = ks_m[1];
    gen_ks(24'hFFFFFF, 1);
    p2 = ks_m[1];
    c = 0;
    for (int v = 0; v < 256; v++) begin
      if (((8'(v) ^ p1) < 8'h20 || (8'(v) ^ p1) > 8'h7E) &&
          ((8'(v) ^ p2) < 8'h20 || (8'(v) ^ p2) > 8'h7E)) begin
        c = v;
        break;
      end
    end
    for (int m = 0; m < 256; m++) ct_m[m] = 8'($urandom_range(0, 255));
    ct_m[0] = 8'd1;
    ct_m[1] = 8'(c);
    load_ct();
    check("exh_model", 64'(model_search(24'hFFFFFE, 1)), 64'(-1));
    pulse_reset(1);
    repeat (3) @(negedge CLOCK_50);
    dut.key = 24'hFFFFFE;
    wait_done("exhaust", 6000);
    check_result("exhaust", -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
